// File: rtl/lsu_split.sv
// Multi-cycle load/store unit with one outstanding bus transaction.
// Word-crossing accesses are either split into two beats or rejected.
module lsu_split #(
  parameter int DWIDTH           = 32,
  parameter int AWIDTH           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH/8-1:0] mem_wbe,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata
);
  localparam int NB = DWIDTH / 8;
  localparam int OB = $clog2(NB);

  // state | meaning: IDLE accept | REQ0/REQ1 beat on bus | WAIT0/WAIT1 await rvalid | RESP hold response
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  state_t state;

  logic              wen_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OB-1:0]     off_q;
  logic              cross_q;
  logic [NB-1:0]     wbe1_q;
  logic [DWIDTH-1:0] wdata1_q;
  logic [DWIDTH-1:0] lo;

  logic [OB-1:0]       in_off;
  logic [3:0]          in_bytes;
  logic [4:0]          in_end;
  logic                in_cross;
  logic                in_err;
  logic [NB-1:0]       in_mask;
  logic [2*NB-1:0]     in_wbe2;
  logic [2*DWIDTH-1:0] in_wdata2;

  always_comb begin
    in_off    = req_addr[OB-1:0];
    in_bytes  = 4'd1 << req_size;
    in_end    = 5'(in_off) + 5'(in_bytes);
    in_cross  = in_end > 5'(NB);
    in_err    = (int'(req_size) > OB) || (in_cross && (ALLOW_MISALIGNED == 0));
    in_mask   = NB'((9'd1 << in_bytes) - 9'd1);
    // Both beats come from one double-width shift: the upper half is the beat-1 spill.
    in_wbe2   = {{NB{1'b0}}, in_mask} << in_off;
    in_wdata2 = {{DWIDTH{1'b0}}, req_wdata} << {in_off, 3'b000};
  end

  logic [DWIDTH-1:0] asm_lo, asm_hi, asm_raw, asm_ext;
  logic              asm_sign, sign_en;
  int                asm_bits;

  always_comb begin
    asm_lo   = (state == WAIT1) ? lo : mem_rdata;
    asm_hi   = (state == WAIT1) ? mem_rdata : '0;
    asm_raw  = DWIDTH'({asm_hi, asm_lo} >> {off_q, 3'b000});
    asm_bits = 8 << size_q;
    if (asm_bits > DWIDTH) asm_bits = DWIDTH;
    sign_en  = !uns_q && (int'(size_q) < OB);
    asm_sign = 1'b0;
    for (int i = 0; i < DWIDTH; i++)
      if (i == asm_bits - 1) asm_sign = asm_raw[i];
    for (int i = 0; i < DWIDTH; i++)
      asm_ext[i] = (i < asm_bits) ? asm_raw[i] : (sign_en & asm_sign);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wbe    <= '0;
      mem_wdata  <= '0;
      wen_q      <= 1'b0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      cross_q    <= 1'b0;
      wbe1_q     <= '0;
      wdata1_q   <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wen_q     <= req_wen;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            off_q     <= in_off;
            cross_q   <= in_cross;
            wbe1_q    <= req_wen ? in_wbe2[2*NB-1:NB] : '0;
            wdata1_q  <= in_wdata2[2*DWIDTH-1:DWIDTH];
            req_ready <= 1'b0;
            if (in_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= REQ0;
              mem_req   <= 1'b1;
              mem_we    <= req_wen;
              mem_addr  <= {req_addr[AWIDTH-1:OB], {OB{1'b0}}};
              mem_wbe   <= req_wen ? in_wbe2[NB-1:0] : '0;
              mem_wdata <= in_wdata2[DWIDTH-1:0];
            end
          end
        end
        REQ0: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            lo <= mem_rdata;
            if (cross_q) begin
              state     <= REQ1;
              mem_req   <= 1'b1;
              mem_addr  <= mem_addr + AWIDTH'(NB);
              mem_wbe   <= wbe1_q;
              mem_wdata <= wdata1_q;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= wen_q ? '0 : asm_ext;
            end
          end
        end
        REQ1: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= wen_q ? '0 : asm_ext;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_split.sv
// Scoreboard bench for lsu_split: stimulus pushes expected beats/responses,
// a bus model and a response monitor pop and compare.
module tb_lsu_split;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_wen = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err;
  logic        resp_ready = 1;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [3:0]  mem_wbe;

  lsu_split #(.DWIDTH(32), .AWIDTH(32), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  // Second instance with splitting disabled; its bus never answers.
  logic        n_req_valid = 0, n_req_ready, n_resp_valid, n_resp_err;
  logic [31:0] n_resp_rdata, n_mem_addr, n_mem_wdata;
  logic        n_mem_req, n_mem_we;
  logic [3:0]  n_mem_wbe;

  lsu_split #(.DWIDTH(32), .AWIDTH(32), .ALLOW_MISALIGNED(0)) dut_nomis (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_wen(1'b0),
    .req_size(2'd2), .req_unsigned(1'b0), .req_addr(32'h8000_0001),
    .req_wdata(32'h0),
    .resp_valid(n_resp_valid), .resp_ready(1'b1), .resp_rdata(n_resp_rdata),
    .resp_err(n_resp_err),
    .mem_req(n_mem_req), .mem_gnt(1'b0), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
    .mem_wbe(n_mem_wbe), .mem_wdata(n_mem_wdata), .mem_rvalid(1'b0),
    .mem_rdata(32'h0)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] wbe; logic [31:0] wdata; logic we; } beat_t;
  resp_t       resp_q[$];
  beat_t       beat_q[$];
  logic [31:0] rd_q[$];

  // Bus model: grant after stall_cfg withheld cycles, rvalid 1+rv_delay cycles later.
  int    stall_cfg = 0, stall_left = 0, rv_delay = 0, rv_cnt = 0;
  int    req_cycles = 0, n_req_cycles = 0;
  logic  snap_v = 0, snap_we;
  logic [31:0] snap_a, snap_d;
  logic [3:0]  snap_b;
  beat_t b;

  always @(negedge clk) begin
    if (n_mem_req) n_req_cycles++;
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
      end
    end
    mem_gnt = 1'b0;
    if (rst) snap_v = 1'b0;
    else if (mem_req) begin
      req_cycles++;
      if (snap_v) begin
        check("hold_mem_addr", mem_addr, snap_a);
        check("hold_mem_wbe", mem_wbe, snap_b);
        check("hold_mem_wdata", mem_wdata, snap_d);
        check("hold_mem_we", mem_we, snap_we);
      end else begin
        snap_v = 1'b1; snap_a = mem_addr; snap_b = mem_wbe;
        snap_d = mem_wdata; snap_we = mem_we;
        stall_left = stall_cfg;
      end
      if (stall_left > 0) stall_left--;
      else begin
        mem_gnt = 1'b1;
        snap_v  = 1'b0;
        rv_cnt  = 1 + rv_delay;
        if (beat_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got addr %0h, want no bus request", mem_addr);
        end else begin
          b = beat_q.pop_front();
          check("beat_addr", mem_addr, b.addr);
          check("beat_wbe", mem_wbe, b.wbe);
          check("beat_wdata", mem_wdata, b.wdata);
          check("beat_we", mem_we, b.we);
        end
      end
    end
  end

  // Response monitor.
  int    hold_cfg = 0, hold_left = 0;
  logic  in_resp = 0;
  resp_t e;

  always @(negedge clk) begin
    if (rst) begin
      resp_ready = 1'b1;
      in_resp    = 1'b0;
    end else if (resp_valid) begin
      if (resp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got rdata %0h err %0b, want no response", resp_rdata, resp_err);
        resp_ready = 1'b1;
      end else begin
        e = resp_q[0];
        if (!in_resp) begin
          in_resp   = 1'b1;
          hold_left = hold_cfg;
          if (e.lat > 0) check("resp_latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
        end
        if (hold_left > 0) begin
          hold_left--;
          resp_ready = 1'b0;
          check("held_rdata", resp_rdata, e.rdata);
          check("held_err", resp_err, e.err);
          check("held_req_ready", req_ready, 1'b0);
        end else begin
          resp_ready = 1'b1;
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", resp_err, e.err);
          void'(resp_q.pop_front());
          in_resp = 1'b0;
        end
      end
    end else resp_ready = 1'b1;
  end

  task automatic exp_beat(input logic [31:0] addr, input logic [3:0] wbe,
                          input logic [31:0] wdata, input logic we);
    beat_t nb;
    nb.addr = addr; nb.wbe = wbe; nb.wdata = wdata; nb.we = we;
    beat_q.push_back(nb);
  endtask

  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] want_rdata, input logic want_err, input int lat);
    resp_t r;
    int    n;
    r.rdata = want_rdata; r.err = want_err; r.lat = lat;
    resp_q.push_back(r);
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout: got req_ready 0, want 1");
    end
    @(posedge clk); #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    n = 0;
    while (resp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL resp_timeout: got no response for addr %0h, want one", addr);
      resp_q.delete();
      beat_q.delete();
    end
    @(negedge clk);
  endtask

  int rc0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wbe", mem_wbe, 4'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);

    exp_beat(32'h8000_0100, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

    exp_beat(32'h8000_0100, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'h8012_3456);
    issue(1'b0, 2'd0, 1'b0, 32'h8000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    exp_beat(32'h8000_0100, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'h8012_3456);
    issue(1'b0, 2'd0, 1'b1, 32'h8000_0103, 32'h0, 32'h0000_0080, 1'b0, 3);
    exp_beat(32'h8000_0100, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'h8012_3456);
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0102, 32'h0, 32'hFFFF_8012, 1'b0, 3);

    exp_beat(32'h8000_0100, 4'b0010, 32'h0000_AA00, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h8000_0101, 32'h0000_00AA, 32'h0, 1'b0, 3);

    exp_beat(32'h8000_0100, 4'b1100, 32'h3344_0000, 1'b1);
    exp_beat(32'h8000_0104, 4'b0011, 32'h0000_1122, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0102, 32'h1122_3344, 32'h0, 1'b0, 5);

    exp_beat(32'h8000_0100, 4'h0, 32'h0, 1'b0); exp_beat(32'h8000_0104, 4'h0, 32'h0, 1'b0);
    rd_q.push_back(32'hAB00_0000); rd_q.push_back(32'h0000_00CD);
    issue(1'b0, 2'd1, 1'b0, 32'h8000_0103, 32'h0, 32'hFFFF_CDAB, 1'b0, 5);
    exp_beat(32'h8000_0100, 4'h0, 32'h0, 1'b0); exp_beat(32'h8000_0104, 4'h0, 32'h0, 1'b0);
    rd_q.push_back(32'hAB00_0000); rd_q.push_back(32'h0000_00CD);
    issue(1'b0, 2'd1, 1'b1, 32'h8000_0103, 32'h0, 32'h0000_CDAB, 1'b0, 5);

    exp_beat(32'hFFFF_FFFC, 4'h0, 32'h0, 1'b0); exp_beat(32'h0000_0000, 4'h0, 32'h0, 1'b0);
    rd_q.push_back(32'h1100_0000); rd_q.push_back(32'h0000_0022);
    issue(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_2211, 1'b0, 5);

    rc0 = req_cycles;
    issue(1'b0, 2'd3, 1'b0, 32'h8000_0100, 32'h0, 32'h0, 1'b1, 1);
    check("err_no_bus", 64'(req_cycles - rc0), 64'd0);

    @(negedge clk);
    n_req_valid = 1'b1;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    check("nomis_resp_valid", n_resp_valid, 1'b1);
    check("nomis_resp_err", n_resp_err, 1'b1);
    check("nomis_resp_rdata", n_resp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    check("nomis_no_bus", 64'(n_req_cycles), 64'd0);
    check("nomis_req_ready", n_req_ready, 1'b1);

    stall_cfg = 3;
    exp_beat(32'h8000_0200, 4'hF, 32'hCAFE_F00D, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0200, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
    stall_cfg = 0;

    hold_cfg = 2;
    exp_beat(32'h8000_0300, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'h1234_5678);
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0300, 32'h0, 32'h1234_5678, 1'b0, 3);
    hold_cfg = 0;

    rv_delay = 3;
    exp_beat(32'h8000_0500, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'h5555_5555);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8000_0500; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_mem_req", mem_req, 1'b0);
    repeat (3) @(negedge clk);
    check("stale_rvalid_resp_valid", resp_valid, 1'b0);
    check("stale_rvalid_req_ready", req_ready, 1'b1);
    check("stale_rvalid_mem_req", mem_req, 1'b0);
    rv_delay = 0;

    exp_beat(32'h8000_0400, 4'h0, 32'h0, 1'b0); rd_q.push_back(32'h0BAD_F00D);
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0400, 32'h0, 32'h0BAD_F00D, 1'b0, 3);

    check("beats_consumed", 64'(beat_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Multi-cycle load/store unit; successor to the single-cycle datapath's combinational memory stage.
- Sits between core EXU/WB and a request/grant/rvalid memory bus; one transaction outstanding.
- Generalised in data width: DWIDTH=32 or 64.
- Adds bus handshakes, optional hardware splitting of misaligned accesses into two beats, and error responses.

Parameters:
- DWIDTH, 32, data/bus width; 32 or 64. NB = DWIDTH/8 byte lanes; OB = log2(NB).
- AWIDTH, 32, byte address width.
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two beats; 0 = error response.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  zero-extend load when 1.
- req_addr  in  AWIDTH  byte address.
- req_wdata  in  DWIDTH  store data, LSB-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  DWIDTH  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected (bad size or misaligned).
- mem_req  out  1  bus request.
- mem_gnt  in  1  bus grant.
- mem_we  out  1  bus write.
- mem_addr  out  AWIDTH  NB-aligned address (low OB bits 0).
- mem_wbe  out  NB  write byte enables.
- mem_wdata  out  DWIDTH  lane-shifted write data.
- mem_rvalid  in  1  read data / write ack, at least 1 cycle after gnt.
- mem_rdata  in  DWIDTH  read data.

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_req=0; mem_we=0; mem_wbe=0; mem_addr=0; mem_wdata=0. Any reset mid-operation aborts to IDLE; no response is produced for the aborted request.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready=1. On req_valid&&req_ready, latch all req_* fields.
  - off = addr[OB-1:0]; bytes = 1<<size; cross = off+bytes > NB.
  - Error case: size > OB, or (cross && !ALLOW_MISALIGNED). Go to RESP with resp_err=1 and rdata=0; no bus activity.
  - Otherwise go to REQ0.
- REQ0:
  - mem_req=1; mem_addr = addr & ~(NB-1); mem_wbe = ((1<<bytes)-1) << off, truncated to NB bits (0 for loads); mem_wdata = wdata << 8*off.
  - All bus outputs held stable until mem_gnt; on gnt go to WAIT0.
- WAIT0: mem_req=0. On mem_rvalid, capture mem_rdata into lo. Go to REQ1 if cross, else RESP.
- REQ1:
  - mem_addr = beat0 address + NB; mem_wbe = ((1<<bytes)-1) >> (NB-off); mem_wdata = wdata >> 8*(NB-off).
  - Same hold-until-gnt rule as REQ0; on gnt go to WAIT1.
- WAIT1: on mem_rvalid, capture hi; go to RESP.
- Load assembly:
  - raw = (lo >> 8*off) | (hi << 8*(NB-off)); hi = 0 when not split.
  - Mask raw to bytes*8 bits. Sign-extend from the top bit unless req_unsigned or size == OB.
- RESP:
  - resp_valid=1; data and err held until resp_ready; return to IDLE on the cycle resp_valid&&resp_ready.
  - req_ready=0 in every state except IDLE; no request is accepted in the same cycle a response completes.
- mem_rvalid is ignored outside WAIT0/WAIT1, including stale rvalid arriving after reset.
- Latency, zero-wait bus (gnt in the cycle after req; rvalid in the cycle after gnt): accept at T, mem_req at T+1, resp_valid at T+3. Split access: resp_valid at T+5. Error: resp_valid at T+1.
- Address increment wraps modulo 2^AWIDTH.

Test Plan (all cases DWIDTH=32):
- Aligned load: LW at 0x80000100, zero-wait bus, rdata 0xDEADBEEF -> mem_addr 0x80000100, mem_wbe 0000, resp_rdata 0xDEADBEEF, resp_valid at T+3.
- Byte loads: at 0x80000103 with rdata 0x80123456, LB -> 0xFFFFFF80; LBU -> 0x00000080. LH at 0x80000102 with same rdata -> 0xFFFF8012.
- Split store: SW at 0x80000102, wdata 0x11223344 -> beat0 addr 0x80000100, wbe 1100, wdata 0x33440000; beat1 addr 0x80000104, wbe 0011, wdata 0x00001122; response at T+5 with rdata 0, err 0.
- Split load: LH at 0x80000103, beat0 rdata 0xAB000000, beat1 rdata 0x000000CD -> resp_rdata 0xFFFFCDAB; with LHU -> 0x0000CDAB.
- Errors: size=3 -> resp_err=1 at T+1, mem_req never asserted. ALLOW_MISALIGNED=0 with LW at 0x80000001 -> resp_err=1, no bus activity.
- Stalls and reset:
  - gnt withheld 3 cycles -> mem_* outputs stable throughout.
  - resp_ready low 2 cycles -> resp_valid/rdata held and req_ready=0.
  - rst pulsed in WAIT0 -> next cycle IDLE, req_ready=1; a following rvalid is ignored; a new LW completes normally.
